// File: rtl/execute_scoreboard.sv
// execute_scoreboard
//   Register scoreboard and issue controller in front of the execute stage.
//   It tracks destination registers whose results are still in flight between
//   issue and writeback. Decode is held off with a valid/ready handshake on RAW
//   or WAW hazards, or when too many tracked writes are outstanding. It also
//   flags writebacks to registers that were not pending and counts stall
//   cycles.
//
// Ports
//   clock, reset_n         rising-edge clock, asynchronous active-low reset
//   issue_*                decode handshake and instruction register fields
//   dispatch_fire          issue_valid & issue_ready (combinational)
//   wb_valid, wb_reg_dest  writeback retirement
//   flush                  synchronous clear of all tracking state
//   busy_mask              pending-write bit per register (bit 0 always 0)
//   inflight_count         number of set bits in busy_mask
//   stall_count            saturating count of issue_valid & !issue_ready cycles
//   wb_error               sticky flag: writeback to a register not pending
module execute_scoreboard #(
   parameter int unsigned MAX_INFLIGHT = 4,
   parameter int unsigned CNT_W        = 3
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [4:0]       issue_rs1,
   input  logic [4:0]       issue_rs2,
   input  logic             issue_uses_rs2,
   input  logic [4:0]       issue_rd,
   input  logic             issue_write_enable,
   output logic             dispatch_fire,
   input  logic             wb_valid,
   input  logic [4:0]       wb_reg_dest,
   input  logic             flush,
   output logic [31:0]      busy_mask,
   output logic [CNT_W-1:0] inflight_count,
   output logic [15:0]      stall_count,
   output logic             wb_error
);

   logic [31:0]      busy_mask_q, busy_mask_d;
   logic [CNT_W-1:0] inflight_count_q, inflight_count_d;
   logic [15:0]      stall_count_q, stall_count_d;
   logic             wb_error_q, wb_error_d;

   logic hazard_rs1, hazard_rs2, hazard_rd, hazard;
   logic tracked_req, full, fire, set_en;
   logic wb_active, wb_hit, wb_miss;

   // Ready depends only on registered state, the issue fields and flush, so a
   // writeback never bypasses into the same-cycle issue decision.
   assign hazard_rs1  = (issue_rs1 != 5'd0) && busy_mask_q[issue_rs1];
   assign hazard_rs2  = issue_uses_rs2 && (issue_rs2 != 5'd0) && busy_mask_q[issue_rs2];
   assign hazard_rd   = issue_write_enable && (issue_rd != 5'd0) && busy_mask_q[issue_rd];
   assign hazard      = hazard_rs1 || hazard_rs2 || hazard_rd;

   assign tracked_req = issue_write_enable && (issue_rd != 5'd0);
   assign full        = (inflight_count_q == CNT_W'(MAX_INFLIGHT));

   // Non-writing instructions and x0 writes are allowed through while full.
   assign issue_ready   = !flush && !hazard && !(full && tracked_req);
   assign fire          = issue_valid && issue_ready;
   assign dispatch_fire = fire;
   assign set_en        = fire && tracked_req;

   // Writeback is ignored during flush and for x0.
   assign wb_active = wb_valid && !flush && (wb_reg_dest != 5'd0);
   assign wb_hit    = wb_active && busy_mask_q[wb_reg_dest];
   assign wb_miss   = wb_active && !busy_mask_q[wb_reg_dest];

   always_comb begin
      busy_mask_d      = busy_mask_q;
      inflight_count_d = inflight_count_q;
      stall_count_d    = stall_count_q;
      wb_error_d       = wb_error_q;

      if (issue_valid && !issue_ready && (stall_count_q != 16'hFFFF)) begin
         stall_count_d = stall_count_q + 16'd1;
      end

      if (flush) begin
         busy_mask_d      = '0;
         inflight_count_d = '0;
      end else begin
         if (set_en) begin
            busy_mask_d[issue_rd] = 1'b1;
         end
         if (wb_hit) begin
            busy_mask_d[wb_reg_dest] = 1'b0;
         end
         if (wb_miss) begin
            wb_error_d = 1'b1;
         end
         // A set and a clear always touch different registers, so they cancel.
         unique case ({set_en, wb_hit})
            2'b10:   inflight_count_d = inflight_count_q + CNT_W'(1);
            2'b01:   inflight_count_d = inflight_count_q - CNT_W'(1);
            default: inflight_count_d = inflight_count_q;
         endcase
      end

      busy_mask_d[0] = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy_mask_q      <= '0;
         inflight_count_q <= '0;
         stall_count_q    <= '0;
         wb_error_q       <= 1'b0;
      end else begin
         busy_mask_q      <= busy_mask_d;
         inflight_count_q <= inflight_count_d;
         stall_count_q    <= stall_count_d;
         wb_error_q       <= wb_error_d;
      end
   end

   assign busy_mask      = busy_mask_q;
   assign inflight_count = inflight_count_q;
   assign stall_count    = stall_count_q;
   assign wb_error       = wb_error_q;

endmodule

// File: tb/tb_execute_scoreboard.sv
// Self-checking bench for execute_scoreboard: directed scenarios followed by
// randomized traffic compared against a register-set reference model.
module tb_execute_scoreboard;

   localparam int unsigned MAX_INFLIGHT = 4;
   localparam int unsigned CNT_W        = 3;

   logic             clock = 1'b0;
   logic             reset_n = 1'b1;
   logic             issue_valid = 1'b0;
   logic             issue_ready;
   logic [4:0]       issue_rs1 = '0;
   logic [4:0]       issue_rs2 = '0;
   logic             issue_uses_rs2 = 1'b0;
   logic [4:0]       issue_rd = '0;
   logic             issue_write_enable = 1'b0;
   logic             dispatch_fire;
   logic             wb_valid = 1'b0;
   logic [4:0]       wb_reg_dest = '0;
   logic             flush = 1'b0;
   logic [31:0]      busy_mask;
   logic [CNT_W-1:0] inflight_count;
   logic [15:0]      stall_count;
   logic             wb_error;

   always #5 clock = ~clock;

   execute_scoreboard #(
      .MAX_INFLIGHT(MAX_INFLIGHT),
      .CNT_W       (CNT_W)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .issue_valid       (issue_valid),
      .issue_ready       (issue_ready),
      .issue_rs1         (issue_rs1),
      .issue_rs2         (issue_rs2),
      .issue_uses_rs2    (issue_uses_rs2),
      .issue_rd          (issue_rd),
      .issue_write_enable(issue_write_enable),
      .dispatch_fire     (dispatch_fire),
      .wb_valid          (wb_valid),
      .wb_reg_dest       (wb_reg_dest),
      .flush             (flush),
      .busy_mask         (busy_mask),
      .inflight_count    (inflight_count),
      .stall_count       (stall_count),
      .wb_error          (wb_error)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: set of registers with a write in flight.
   bit m_pend[32];
   int m_stall;
   bit m_err;

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < 32; i++) if (m_pend[i]) c++;
      return c;
   endfunction

   function automatic logic [31:0] m_mask();
      logic [31:0] v = '0;
      for (int i = 0; i < 32; i++) v[i] = m_pend[i];
      return v;
   endfunction

   function automatic bit m_ready();
      bit haz;
      bit wr;
      wr  = issue_write_enable && (issue_rd != 0);
      haz = (issue_rs1 != 0 && m_pend[issue_rs1]) ||
            (issue_uses_rs2 && issue_rs2 != 0 && m_pend[issue_rs2]) ||
            (wr && m_pend[issue_rd]);
      return !flush && !haz && !(m_count() == int'(MAX_INFLIGHT) && wr);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      m_stall = 0;
      m_err   = 1'b0;
   endtask

   // Applies one clock edge to the model using the inputs present at the edge.
   task automatic model_clock();
      bit r;
      r = m_ready();
      if (issue_valid && !r && m_stall < 65535) m_stall++;
      if (flush) begin
         for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      end else begin
         if (wb_valid && wb_reg_dest != 0) begin
            if (m_pend[wb_reg_dest]) m_pend[wb_reg_dest] = 1'b0;
            else m_err = 1'b1;
         end
         if (issue_valid && r && issue_write_enable && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      end
   endtask

   task automatic set_in(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit u2, input logic [4:0] rd, input bit we,
                         input bit wv, input logic [4:0] wd, input bit fl);
      issue_valid        = v;
      issue_rs1          = rs1;
      issue_rs2          = rs2;
      issue_uses_rs2     = u2;
      issue_rd           = rd;
      issue_write_enable = we;
      wb_valid           = wv;
      wb_reg_dest        = wd;
      flush              = fl;
   endtask

   task automatic cycle();
      @(posedge clock);
      model_clock();
      @(negedge clock);
   endtask

   task automatic test_reset();
      set_in(1, 5, 0, 0, 5, 1, 0, 0, 0);
      #1 reset_n = 1'b0;
      #1;
      m_reset();
      n_cmp++; if (busy_mask !== 32'h0) begin n_fail++;
         $display("FAIL reset_mask got %h want 0", busy_mask); end
      n_cmp++; if (inflight_count !== 3'd0) begin n_fail++;
         $display("FAIL reset_count got %0d want 0", inflight_count); end
      n_cmp++; if (stall_count !== 16'd0) begin n_fail++;
         $display("FAIL reset_stall got %0d want 0", stall_count); end
      n_cmp++; if (wb_error !== 1'b0) begin n_fail++;
         $display("FAIL reset_err got %b want 0", wb_error); end
      n_cmp++; if (issue_ready !== 1'b1 || dispatch_fire !== 1'b1) begin n_fail++;
         $display("FAIL reset_ready got %b/%b want 1/1", issue_ready, dispatch_fire); end
      @(negedge clock);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      reset_n = 1'b1;
      cycle();
      n_cmp++; if (busy_mask !== 32'h0 || stall_count !== 16'd0) begin n_fail++;
         $display("FAIL post_release got %h/%0d want 0/0", busy_mask, stall_count); end
   endtask

   task automatic test_raw();
      set_in(1, 0, 0, 0, 5, 1, 0, 0, 0);
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_fail++;
         $display("FAIL raw_first_ready got %b want 1", issue_ready); end
      cycle();
      n_cmp++; if (busy_mask !== 32'h20 || inflight_count !== 3'd1) begin n_fail++;
         $display("FAIL raw_set got %h/%0d want 00000020/1", busy_mask, inflight_count); end
      for (int c = 2; c <= 4; c++) begin
         set_in(1, 5, 0, 0, 0, 0, (c == 4), 5, 0);
         #1;
         n_cmp++; if (issue_ready !== 1'b0 || dispatch_fire !== 1'b0) begin n_fail++;
            $display("FAIL raw_stall_c%0d got %b/%b want 0/0", c, issue_ready, dispatch_fire); end
         cycle();
      end
      n_cmp++; if (stall_count !== 16'd3 || busy_mask !== 32'h0) begin n_fail++;
         $display("FAIL raw_after_wb got %0d/%h want 3/0", stall_count, busy_mask); end
      set_in(1, 5, 0, 0, 0, 0, 0, 0, 0);
      #1;
      n_cmp++; if (issue_ready !== 1'b1 || dispatch_fire !== 1'b1) begin n_fail++;
         $display("FAIL raw_release got %b/%b want 1/1", issue_ready, dispatch_fire); end
      cycle();
      n_cmp++; if (busy_mask !== 32'h0 || stall_count !== 16'd3) begin n_fail++;
         $display("FAIL raw_done got %h/%0d want 0/3", busy_mask, stall_count); end
   endtask

   task automatic test_full();
      for (int r = 1; r <= 4; r++) begin
         set_in(1, 0, 0, 0, 5'(r), 1, 0, 0, 0);
         #1;
         n_cmp++; if (issue_ready !== 1'b1) begin n_fail++;
            $display("FAIL full_fill_x%0d got %b want 1", r, issue_ready); end
         cycle();
      end
      n_cmp++; if (busy_mask !== 32'h1E || inflight_count !== 3'd4) begin n_fail++;
         $display("FAIL full_filled got %h/%0d want 0000001e/4", busy_mask, inflight_count); end
      set_in(1, 0, 0, 0, 6, 1, 0, 0, 0);
      #1;
      n_cmp++; if (issue_ready !== 1'b0) begin n_fail++;
         $display("FAIL full_write_blocked got %b want 0", issue_ready); end
      cycle();
      set_in(1, 7, 0, 0, 0, 0, 0, 0, 0);
      #1;
      n_cmp++; if (issue_ready !== 1'b1 || dispatch_fire !== 1'b1) begin n_fail++;
         $display("FAIL full_nonwrite got %b/%b want 1/1", issue_ready, dispatch_fire); end
      cycle();
      set_in(1, 0, 0, 0, 6, 1, 1, 2, 0);
      #1;
      n_cmp++; if (issue_ready !== 1'b0) begin n_fail++;
         $display("FAIL full_no_bypass got %b want 0", issue_ready); end
      cycle();
      n_cmp++; if (busy_mask !== 32'h1A || inflight_count !== 3'd3) begin n_fail++;
         $display("FAIL full_retire got %h/%0d want 0000001a/3", busy_mask, inflight_count); end
      set_in(1, 0, 0, 0, 6, 1, 0, 0, 0);
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_fail++;
         $display("FAIL full_x6_ready got %b want 1", issue_ready); end
      cycle();
      n_cmp++; if (busy_mask !== 32'h5A || inflight_count !== 3'd4) begin n_fail++;
         $display("FAIL full_x6 got %h/%0d want 0000005a/4", busy_mask, inflight_count); end
      foreach (m_pend[r]) begin
         if (r == 1 || r == 3 || r == 4 || r == 6) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 5'(r), 0);
            cycle();
         end
      end
      n_cmp++; if (busy_mask !== 32'h0 || inflight_count !== 3'd0) begin n_fail++;
         $display("FAIL full_drain got %h/%0d want 0/0", busy_mask, inflight_count); end
   endtask

   task automatic test_imm_x0();
      set_in(1, 0, 0, 0, 9, 1, 0, 0, 0);
      cycle();
      set_in(0, 0, 9, 1, 0, 0, 0, 0, 0);
      #1;
      n_cmp++; if (issue_ready !== 1'b0) begin n_fail++;
         $display("FAIL imm_rs2_used got %b want 0", issue_ready); end
      set_in(1, 0, 9, 0, 0, 0, 0, 0, 0);
      #1;
      n_cmp++; if (issue_ready !== 1'b1 || dispatch_fire !== 1'b1) begin n_fail++;
         $display("FAIL imm_rs2_ignored got %b/%b want 1/1", issue_ready, dispatch_fire); end
      cycle();
      set_in(1, 0, 0, 0, 0, 1, 0, 0, 0);
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_fail++;
         $display("FAIL x0_ready got %b want 1", issue_ready); end
      cycle();
      n_cmp++; if (busy_mask !== 32'h200 || inflight_count !== 3'd1) begin n_fail++;
         $display("FAIL x0_mask got %h/%0d want 00000200/1", busy_mask, inflight_count); end
      set_in(0, 0, 0, 0, 0, 0, 1, 9, 0);
      cycle();
   endtask

   task automatic test_simul_err();
      set_in(1, 0, 0, 0, 1, 1, 0, 0, 0);
      cycle();
      n_cmp++; if (busy_mask !== 32'h2) begin n_fail++;
         $display("FAIL simul_pre got %h want 00000002", busy_mask); end
      set_in(1, 0, 0, 0, 3, 1, 1, 1, 0);
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_fail++;
         $display("FAIL simul_ready got %b want 1", issue_ready); end
      cycle();
      n_cmp++; if (busy_mask !== 32'h8 || inflight_count !== 3'd1) begin n_fail++;
         $display("FAIL simul_swap got %h/%0d want 00000008/1", busy_mask, inflight_count); end
      set_in(0, 0, 0, 0, 0, 0, 1, 3, 0);
      cycle();
      n_cmp++; if (wb_error !== 1'b0) begin n_fail++;
         $display("FAIL err_clean got %b want 0", wb_error); end
      set_in(0, 0, 0, 0, 0, 0, 1, 7, 0);
      cycle();
      n_cmp++; if (wb_error !== 1'b1 || busy_mask !== 32'h0) begin n_fail++;
         $display("FAIL err_set got %b/%h want 1/0", wb_error, busy_mask); end
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) cycle();
      n_cmp++; if (wb_error !== 1'b1) begin n_fail++;
         $display("FAIL err_sticky got %b want 1", wb_error); end
   endtask

   task automatic test_flush();
      for (int r = 1; r <= 3; r++) begin
         set_in(1, 0, 0, 0, 5'(r), 1, 0, 0, 0);
         cycle();
      end
      n_cmp++; if (inflight_count !== 3'd3) begin n_fail++;
         $display("FAIL flush_pre got %0d want 3", inflight_count); end
      set_in(1, 0, 0, 0, 4, 1, 1, 1, 1);
      #1;
      n_cmp++; if (issue_ready !== 1'b0 || dispatch_fire !== 1'b0) begin n_fail++;
         $display("FAIL flush_ready got %b/%b want 0/0", issue_ready, dispatch_fire); end
      cycle();
      n_cmp++; if (busy_mask !== 32'h0 || inflight_count !== 3'd0) begin n_fail++;
         $display("FAIL flush_clear got %h/%0d want 0/0", busy_mask, inflight_count); end
      n_cmp++; if (wb_error !== 1'b1 || stall_count !== 16'(m_stall)) begin n_fail++;
         $display("FAIL flush_hold got %b/%0d want 1/%0d", wb_error, stall_count, m_stall); end
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      bit exp_r;
      for (int i = 0; i < 1500; i++) begin
         set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom_range(0, 31) == 0);
         #1;
         exp_r = m_ready();
         n_cmp++; if (issue_ready !== exp_r || dispatch_fire !== (issue_valid && exp_r)) begin
            n_fail++;
            $display("FAIL rnd_ready[%0d] got %b/%b want %b/%b", i, issue_ready, dispatch_fire,
                     exp_r, issue_valid && exp_r);
         end
         cycle();
         n_cmp++; if (busy_mask !== m_mask() || inflight_count !== CNT_W'(m_count())) begin
            n_fail++;
            $display("FAIL rnd_state[%0d] got %h/%0d want %h/%0d", i, busy_mask, inflight_count,
                     m_mask(), m_count());
         end
         n_cmp++; if (stall_count !== 16'(m_stall) || wb_error !== m_err) begin n_fail++;
            $display("FAIL rnd_stat[%0d] got %0d/%b want %0d/%b", i, stall_count, wb_error,
                     m_stall, m_err);
         end
      end
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
      cycle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_saturation();
      set_in(1, 0, 0, 0, 5, 1, 0, 0, 0);
      cycle();
      set_in(1, 5, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 65540; i++) begin
         @(posedge clock);
         model_clock();
      end
      @(negedge clock);
      n_cmp++; if (stall_count !== 16'hFFFF || m_stall != 65535) begin n_fail++;
         $display("FAIL sat_hold got %h want ffff", stall_count); end
      n_cmp++; if (issue_ready !== 1'b0) begin n_fail++;
         $display("FAIL sat_ready got %b want 0", issue_ready); end
   endtask

   task automatic test_reset_mid();
      #2 reset_n = 1'b0;
      #1;
      m_reset();
      n_cmp++; if (busy_mask !== 32'h0 || inflight_count !== 3'd0 || stall_count !== 16'd0 ||
                   wb_error !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset got %h/%0d/%0d/%b want 0/0/0/0", busy_mask, inflight_count,
                  stall_count, wb_error);
      end
      n_cmp++; if (issue_ready !== 1'b1) begin n_fail++;
         $display("FAIL midreset_ready got %b want 1", issue_ready); end
      @(negedge clock);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b1;
      set_in(1, 0, 0, 0, 5, 1, 0, 0, 0);
      cycle();
      n_cmp++; if (busy_mask !== 32'h20 || inflight_count !== 3'd1) begin n_fail++;
         $display("FAIL midreset_after got %h/%0d want 00000020/1", busy_mask, inflight_count); end
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_raw();
      test_full();
      test_imm_x0();
      test_simul_err();
      test_flush();
      test_random();
      test_saturation();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
